uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with mid-bit sampling and output FIFO
module uart_rx_param #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_WIDTH       = 8,
  parameter int PARITY_MODE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rx_wire_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_err_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  frame_err_out,
  output logic                  overrun_out,
  output logic                  busy_out
);

  localparam int BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD >> 1;
  localparam int CW         = $clog2(BIT_PERIOD);
  localparam int BW         = $clog2(DATA_WIDTH + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t state, state_next;

  logic                  rx_meta, rx_s;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, remain;

  logic at_half, at_last, stop_last;
  logic push, frame_err, shift_en, par_en;
  logic full, pop, push_ok;

  assign at_half   = (cnt == CNT_HALF);
  assign at_last   = (cnt == CNT_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign busy_out  = (state != IDLE);
  assign valid_out = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = valid_out && ready_in;
  assign push_ok   = push && (!full || pop);
  assign remain    = count - (AW+1)'(pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    frame_err  = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: begin
        if (at_half && rx_s) state_next = IDLE;
        else if (at_last)    state_next = DATA;
      end
      DATA: begin
        shift_en = at_half;
        if (at_last && bit_idx == BIT_LAST)
          state_next = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: begin
        par_en = at_half;
        if (at_last) state_next = STOP;
      end
      STOP: begin
        // The last stop bit ends the frame at its midpoint so a following start edge is not missed.
        if (at_half && !rx_s) begin
          frame_err  = 1'b1;
          state_next = WAIT_HIGH;
        end else if (at_half && stop_last) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      cnt            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      perr           <= 1'b0;
      frame_err_out  <= 1'b0;
      overrun_out    <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      parity_err_out <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rx_meta <= rx_wire_in;
      rx_s    <= rx_meta;

      if (state == IDLE || state == WAIT_HIGH || state_next == IDLE || state_next == WAIT_HIGH || at_last)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (state == IDLE) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        perr     <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (par_en)                perr     <= ((^shreg) ^ rx_s) != (PARITY_MODE == 1);
      if (state == STOP && at_last) stop_idx <= 1'b1;

      frame_err_out <= frame_err;
      overrun_out   <= push && full && !pop;

      if (push_ok) begin
        mem[wr_ptr] <= {perr, shreg};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // Head is registered so it survives the FIFO draining empty.
      if (remain != '0)
        {parity_err_out, data_out} <= mem[rd_ptr + AW'(pop)];
      else if (push_ok)
        {parity_err_out, data_out} <= {perr, shreg};
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param in three configurations
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_p, rst_c;
  logic rx_a, rx_p, rx_c;
  logic rdy_a, rdy_p, rdy_c;
  logic [7:0] d_a, d_p;
  logic [6:0] d_c;
  logic pe_a, pe_p, pe_c, v_a, v_p, v_c, fe_a, fe_p, fe_c;
  logic ov_a, ov_p, ov_c, bz_a, bz_p, bz_c;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic       m_v, m_p, m_fe, m_ov, m_busy;
  logic [8:0] m_d;

  always_comb begin
    m_v = v_a; m_p = pe_a; m_fe = fe_a; m_ov = ov_a; m_busy = bz_a; m_d = {1'b0, d_a};
    case (sel)
      1: begin m_v = v_p; m_p = pe_p; m_fe = fe_p; m_ov = ov_p; m_busy = bz_p; m_d = {1'b0, d_p}; end
      2: begin m_v = v_c; m_p = pe_c; m_fe = fe_c; m_ov = ov_c; m_busy = bz_c; m_d = {2'b0, d_c}; end
      default: ;
    endcase
  end

  uart_rx_param #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) u_a (
    .clk_in(clk), .rst_n_in(rst_a), .rx_wire_in(rx_a), .data_out(d_a), .parity_err_out(pe_a),
    .valid_out(v_a), .ready_in(rdy_a), .frame_err_out(fe_a), .overrun_out(ov_a), .busy_out(bz_a));

  uart_rx_param #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_MODE(2)) u_p (
    .clk_in(clk), .rst_n_in(rst_p), .rx_wire_in(rx_p), .data_out(d_p), .parity_err_out(pe_p),
    .valid_out(v_p), .ready_in(rdy_p), .frame_err_out(fe_p), .overrun_out(ov_p), .busy_out(bz_p));

  uart_rx_param #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(7), .STOP_BITS(2)) u_c (
    .clk_in(clk), .rst_n_in(rst_c), .rx_wire_in(rx_c), .data_out(d_c), .parity_err_out(pe_c),
    .valid_out(v_c), .ready_in(rdy_c), .frame_err_out(fe_c), .overrun_out(ov_c), .busy_out(bz_c));

  // Bit 0 is the start bit; unused upper bits stay high (idle line).
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int dw, input int pbit,
                                             input logic [1:0] stops, input int nstop);
    logic [15:0] b;
    int pos;
    b = '1;
    b[0] = 1'b0;
    pos = 1;
    for (int i = 0; i < dw; i++) begin b[pos] = d[i]; pos = pos + 1; end
    if (pbit >= 0) begin b[pos] = pbit[0]; pos = pos + 1; end
    for (int i = 0; i < nstop; i++) begin b[pos] = stops[i]; pos = pos + 1; end
    return b;
  endfunction

  task automatic set_rx(input int which, input logic v);
    case (which)
      1:       rx_p = v;
      2:       rx_c = v;
      default: rx_a = v;
    endcase
  endtask

  // Entered and left at posedge+1; sample k reflects the DUT after the k-th edge from the start.
  task automatic run_frame(input int which, input logic [15:0] bits, input int nbits, input int bp,
                           input int tail, output int fv, output int vc, output logic [8:0] d,
                           output logic p, output int fe, output int ov, output logic busy_end);
    int tot;
    tot = nbits * bp + tail;
    fv = -1; vc = 0; d = '0; p = 1'b0; fe = 0; ov = 0; busy_end = 1'b0;
    sel = which;
    for (int k = 0; k < tot; k++) begin
      set_rx(which, (k < nbits * bp) ? bits[k / bp] : 1'b1);
      #3;
      if (m_v) begin
        vc++;
        if (fv < 0) begin fv = k; d = m_d; p = m_p; end
      end
      if (m_fe) fe++;
      if (m_ov) ov++;
      busy_end = m_busy;
      @(posedge clk); #1;
    end
  endtask

  int fv, vc, fe, ov;
  logic [8:0] d;
  logic p, be;

  task automatic test_reset();
    total++; if ({v_a, d_a, pe_a, fe_a, ov_a, bz_a} !== '0) begin bad++; $display("FAIL reset_a got=%b exp=0", {v_a, d_a, pe_a, fe_a, ov_a, bz_a}); end
    total++; if ({v_p, d_p, pe_p, fe_p, ov_p, bz_p} !== '0) begin bad++; $display("FAIL reset_p got=%b exp=0", {v_p, d_p, pe_p, fe_p, ov_p, bz_p}); end
    total++; if ({v_c, d_c, pe_c, fe_c, ov_c, bz_c} !== '0) begin bad++; $display("FAIL reset_c got=%b exp=0", {v_c, d_c, pe_c, fe_c, ov_c, bz_c}); end
  endtask

  task automatic test_basic();
    run_frame(0, frame_bits(9'hA5, 8, -1, 2'b11, 1), 10, 10, 30, fv, vc, d, p, fe, ov, be);
    total++; if (fv !== 98)     begin bad++; $display("FAIL basic_latency got=%0d exp=98", fv); end
    total++; if (vc !== 1)      begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", vc); end
    total++; if (d !== 9'h0A5)  begin bad++; $display("FAIL basic_data got=%h exp=a5", d); end
    total++; if (p !== 1'b0)    begin bad++; $display("FAIL basic_perr got=%b exp=0", p); end
    total++; if (fe + ov !== 0) begin bad++; $display("FAIL basic_flags got=%0d exp=0", fe + ov); end
  endtask

  task automatic test_glitch();
    run_frame(0, 16'hFFFE, 1, 3, 40, fv, vc, d, p, fe, ov, be);
    total++; if (vc !== 0)      begin bad++; $display("FAIL glitch_valid got=%0d exp=0", vc); end
    total++; if (fe + ov !== 0) begin bad++; $display("FAIL glitch_flags got=%0d exp=0", fe + ov); end
    total++; if (be !== 1'b0)   begin bad++; $display("FAIL glitch_busy got=%b exp=0", be); end
    run_frame(0, frame_bits(9'h3C, 8, -1, 2'b11, 1), 10, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h03C || vc !== 1) begin bad++; $display("FAIL glitch_next got=%h/%0d exp=3c/1", d, vc); end
    total++; if (fv !== 98)     begin bad++; $display("FAIL glitch_next_latency got=%0d exp=98", fv); end
  endtask

  task automatic test_parity();
    run_frame(1, frame_bits(9'h07, 8, 1, 2'b11, 1), 11, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h007 || vc !== 1) begin bad++; $display("FAIL parity_ok_data got=%h/%0d exp=07/1", d, vc); end
    total++; if (p !== 1'b0)    begin bad++; $display("FAIL parity_ok_perr got=%b exp=0", p); end
    total++; if (fv !== 108)    begin bad++; $display("FAIL parity_latency got=%0d exp=108", fv); end
    run_frame(1, frame_bits(9'h07, 8, 0, 2'b11, 1), 11, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h007 || vc !== 1) begin bad++; $display("FAIL parity_bad_data got=%h/%0d exp=07/1", d, vc); end
    total++; if (p !== 1'b1)    begin bad++; $display("FAIL parity_bad_perr got=%b exp=1", p); end
  endtask

  task automatic test_framing();
    run_frame(0, frame_bits(9'h5A, 8, -1, 2'b00, 1) & 16'h83FF, 15, 10, 40, fv, vc, d, p, fe, ov, be);
    total++; if (fe !== 1)      begin bad++; $display("FAIL framing_pulse got=%0d exp=1", fe); end
    total++; if (vc !== 0)      begin bad++; $display("FAIL framing_push got=%0d exp=0", vc); end
    total++; if (ov !== 0)      begin bad++; $display("FAIL framing_overrun got=%0d exp=0", ov); end
    run_frame(0, frame_bits(9'h11, 8, -1, 2'b11, 1), 10, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h011 || vc !== 1 || fe !== 0) begin bad++; $display("FAIL framing_next got=%h/%0d/%0d exp=11/1/0", d, vc, fe); end
  endtask

  task automatic test_overrun();
    int ov_tot, ov_last;
    ov_tot = 0; ov_last = 0;
    rdy_a = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      run_frame(0, frame_bits(9'(f), 8, -1, 2'b11, 1), 10, 10, (f == 5) ? 20 : 0, fv, vc, d, p, fe, ov, be);
      ov_tot += ov;
      if (f == 5) ov_last = ov;
    end
    total++; if (ov_tot !== 1)  begin bad++; $display("FAIL overrun_total got=%0d exp=1", ov_tot); end
    total++; if (ov_last !== 1) begin bad++; $display("FAIL overrun_frame5 got=%0d exp=1", ov_last); end
    rdy_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #3;
      total++; if (m_v !== 1'b1 || m_d !== 9'(i)) begin bad++; $display("FAIL overrun_pop%0d got=%b/%h exp=1/%h", i, m_v, m_d, 9'(i)); end
      @(posedge clk); #1;
    end
    #3;
    total++; if (m_v !== 1'b0)  begin bad++; $display("FAIL overrun_empty got=%b exp=0", m_v); end
    total++; if (m_d !== 9'h004) begin bad++; $display("FAIL overrun_hold got=%h exp=04", m_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset_two_stop();
    rdy_c = 1'b0;
    run_frame(2, frame_bits(9'h2A, 7, -1, 2'b11, 2), 10, 10, 10, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h02A)  begin bad++; $display("FAIL two_stop_preload got=%h exp=2a", d); end
    rx_c = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    total++; if (m_busy !== 1'b1 || m_v !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b%b exp=11", m_busy, m_v); end
    #2 rst_c = 1'b0;
    #1;
    total++; if ({m_v, m_d, m_p, m_busy} !== '0) begin bad++; $display("FAIL async_reset got=%b exp=0", {m_v, m_d, m_p, m_busy}); end
    rx_c = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_c = 1'b1;
    rdy_c = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run_frame(2, frame_bits(9'h55, 7, -1, 2'b11, 2), 10, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (d !== 9'h055 || vc !== 1) begin bad++; $display("FAIL two_stop_data got=%h/%0d exp=55/1", d, vc); end
    total++; if (fv !== 98)     begin bad++; $display("FAIL two_stop_latency got=%0d exp=98", fv); end
    total++; if (fe !== 0)      begin bad++; $display("FAIL two_stop_clean got=%0d exp=0", fe); end
    run_frame(2, frame_bits(9'h55, 7, -1, 2'b01, 2), 10, 10, 20, fv, vc, d, p, fe, ov, be);
    total++; if (fe !== 1)      begin bad++; $display("FAIL second_stop_ferr got=%0d exp=1", fe); end
    total++; if (vc !== 0)      begin bad++; $display("FAIL second_stop_push got=%0d exp=0", vc); end
    total++; if (be !== 1'b0)   begin bad++; $display("FAIL second_stop_idle got=%b exp=0", be); end
  endtask

  initial begin
    rst_a = 1'b0; rst_p = 1'b0; rst_c = 1'b0;
    rx_a = 1'b1; rx_p = 1'b1; rx_c = 1'b1;
    rdy_a = 1'b1; rdy_p = 1'b1; rdy_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_a = 1'b1; rst_p = 1'b1; rst_c = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    test_basic();
    test_glitch();
    test_parity();
    test_framing();
    test_overrun();
    test_async_reset_two_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
